geofence_feeder: RTL

//  Transmit side of the geofence object stream. Buffers host-written objects
//  (1 test point + 6 fence vertices) and streams them on X/Y in lockstep with the

---
 rtl/geofence_pkg.sv | 23 ++
 rtl/geofence_obj_fifo.sv | 56 +++++
 rtl/geofence_feeder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence object feeder.
// Combinational only; no latency.
// No flow control here.
package geofence_pkg;

  localparam int CW_DEF        = 10;
  localparam int N_VERT        = 6;
  localparam int WORDS_PER_OBJ = N_VERT + 1;
  localparam int IDX_W         = $clog2(WORDS_PER_OBJ);

  // One host word: a test point or a fence vertex
  typedef struct packed {
    logic [CW_DEF-1:0] x;
    logic [CW_DEF-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    ST_SLOT = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/geofence_obj_fifo.sv
// Object buffer: DEPTH objects of WORDS_PER_OBJ words, written word by word, committed/popped per object.
// Writes land on the clock edge; the read port is combinational from (rd_head, rd_idx).
// No internal backpressure: the caller must respect count before starting a new object.
module geofence_obj_fifo
  import geofence_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = CW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [CW-1:0]              wr_x,
  input  logic [CW-1:0]              wr_y,
  input  logic                       commit,
  input  logic                       pop,
  input  logic [$clog2(DEPTH)-1:0]   rd_head,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [CW-1:0]              rd_x,
  output logic [CW-1:0]              rd_y,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] mem_x [DEPTH][WORDS_PER_OBJ];
  logic [CW-1:0] mem_y [DEPTH][WORDS_PER_OBJ];
  logic [PW-1:0] tail;

  // Word store: the object under construction always lives at tail
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[tail][wr_idx] <= wr_x;
      mem_y[tail][wr_idx] <= wr_y;
    end
  end

  // Object pointers and committed-object count; push and pop may coincide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (commit) tail <= tail + PW'(1);
      if (pop)    head <= head + PW'(1);
      count <= count + (PW+1)'(commit) - (PW+1)'(pop);
    end
  end

  assign rd_x = mem_x[rd_head][rd_idx];
  assign rd_y = mem_y[rd_head][rd_idx];

endmodule

// File: rtl/geofence_feeder.sv
// Streams buffered objects to the free-running geofence core and returns tagged results.
// X/Y registered and lockstep with the core; result 1 cycle after valid.
// in_ready drops when the buffer is full; a started object always finishes loading.
module geofence_feeder
  import geofence_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = CW_DEF,
  parameter int ID_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_x,
  input  logic [CW-1:0]   in_y,
  output logic [CW-1:0]   X,
  output logic [CW-1:0]   Y,
  input  logic            valid,
  input  logic            is_inside,
  output logic            res_valid,
  output logic            res_inside,
  output logic [ID_W-1:0] res_id,
  output logic [7:0]      dummy_runs
);

  localparam int PW = $clog2(DEPTH);

  feeder_state_t  state, state_nxt;
  logic [IDX_W-1:0] vcnt, vcnt_nxt;
  logic           run_real, run_real_nxt;
  logic [IDX_W-1:0] wcnt;
  logic           word_acc, obj_commit, obj_pop, dummy_end;
  logic [PW-1:0]  head, rd_head;
  logic [IDX_W-1:0] rd_idx;
  logic [CW-1:0]  rd_x, rd_y;
  logic [PW:0]    count, count_nxt;
  logic           load_word;
  logic [ID_W-1:0] tag_cnt;

  // A partial object already holds its slot, so its remaining words are never refused
  assign in_ready   = reset && ((wcnt != '0) || (count < (PW+1)'(DEPTH)));
  assign word_acc   = in_valid && in_ready;
  assign obj_commit = word_acc && (wcnt == IDX_W'(WORDS_PER_OBJ-1));
  assign obj_pop    = (state == ST_WAIT) && valid && run_real;
  assign dummy_end  = (state == ST_WAIT) && valid && !run_real;
  assign count_nxt  = count + (PW+1)'(obj_commit) - (PW+1)'(obj_pop);

  geofence_obj_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (word_acc),
    .wr_idx  (wcnt),
    .wr_x    (in_x),
    .wr_y    (in_y),
    .commit  (obj_commit),
    .pop     (obj_pop),
    .rd_head (rd_head),
    .rd_idx  (rd_idx),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .head    (head),
    .count   (count)
  );

  // Host word position within the object being loaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        wcnt <= '0;
    else if (word_acc) wcnt <= obj_commit ? '0 : wcnt + IDX_W'(1);
  end

  // State register; the first cycle out of reset is a slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_SLOT;
      vcnt     <= '0;
      run_real <= 1'b0;
    end else begin
      state    <= state_nxt;
      vcnt     <= vcnt_nxt;
      run_real <= run_real_nxt;
    end
  end

  // Next state, and which buffered word X/Y must carry in the next cycle
  always_comb begin
    state_nxt    = state;
    vcnt_nxt     = vcnt;
    run_real_nxt = run_real;
    rd_head      = head;
    rd_idx       = '0;
    load_word    = 1'b0;
    unique case (state)
      ST_SLOT: begin
        state_nxt = ST_SEND;
        vcnt_nxt  = '0;
        rd_idx    = IDX_W'(1);
        load_word = run_real;
      end
      ST_SEND: begin
        if (vcnt == IDX_W'(N_VERT-1)) begin
          state_nxt = ST_WAIT;
        end else begin
          vcnt_nxt  = vcnt + IDX_W'(1);
          rd_idx    = vcnt + IDX_W'(2);
          load_word = run_real;
        end
      end
      ST_WAIT: begin
        if (valid) begin
          // Slot decision uses occupancy after this edge's push/pop
          state_nxt    = ST_SLOT;
          run_real_nxt = (count_nxt != '0);
          rd_head      = head + PW'(obj_pop);
          load_word    = run_real_nxt;
        end
      end
      default: state_nxt = ST_SLOT;
    endcase
  end

  // Coordinate outputs; dummy runs and the wait phase drive zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      X <= '0;
      Y <= '0;
    end else begin
      X <= load_word ? rd_x : '0;
      Y <= load_word ? rd_y : '0;
    end
  end

  // Result pulse, head tag and saturating dummy-run counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid  <= 1'b0;
      res_inside <= 1'b0;
      res_id     <= '0;
      tag_cnt    <= '0;
      dummy_runs <= '0;
    end else begin
      res_valid <= obj_pop;
      if (obj_pop) begin
        res_inside <= is_inside;
        res_id     <= tag_cnt;
        tag_cnt    <= tag_cnt + ID_W'(1);
      end
      if (dummy_end && (dummy_runs != 8'hFF)) dummy_runs <= dummy_runs + 8'd1;
    end
  end

endmodule
